// File: rtl/arb_req_master.sv
// Requester-side agent for the round-robin arbiter: turns per-channel burst commands
// into held request lines and reports beat, done, starvation-timeout and protocol-error status.
module arb_req_master #(
  parameter int unsigned NumReq        = 3,
  parameter int unsigned LenW          = 4,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [NumReq-1:0]      start_in,
  output logic [NumReq-1:0]      start_ready_out,
  input  logic [NumReq*LenW-1:0] len_in,
  output logic [NumReq-1:0]      req_out,
  input  logic [NumReq-1:0]      grant_in,
  output logic [NumReq-1:0]      beat_out,
  output logic [NumReq-1:0]      done_out,
  output logic [NumReq-1:0]      timeout_out,
  output logic                   err_out,
  output logic                   busy_out
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  logic grant_multi;
  logic grant_orphan;

  assign beat_out     = req_out & grant_in;
  assign busy_out     = ~&start_ready_out;
  assign grant_multi  = |(grant_in & (grant_in - NumReq'(1)));
  assign grant_orphan = |(grant_in & ~req_out);

  // Sticky protocol error: overlapping grants or a grant to a channel not requesting.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      err_out <= 1'b0;
    end else if (grant_multi || grant_orphan) begin
      err_out <= 1'b1;
    end
  end

  for (genvar i = 0; i < NumReq; i++) begin : g_ch
    state_e          st;
    logic [LenW-1:0] rem;
    logic [CntW-1:0] wcnt;
    logic            req_q;
    logic            rdy_q;
    logic            done_q;
    logic            to_q;
    logic            gnt;

    assign gnt                = grant_in[i];
    assign req_out[i]         = req_q;
    assign start_ready_out[i] = rdy_q;
    assign done_out[i]        = done_q;
    assign timeout_out[i]     = to_q;

    // Per-channel burst FSM; outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
      if (!rstN) begin
        st     <= S_IDLE;
        rem    <= '0;
        wcnt   <= '0;
        req_q  <= 1'b0;
        rdy_q  <= 1'b1;
        done_q <= 1'b0;
        to_q   <= 1'b0;
      end else begin
        done_q <= 1'b0;
        to_q   <= 1'b0;
        case (st)
          S_IDLE: begin
            if (start_in[i]) begin
              st    <= S_WAIT;
              rem   <= len_in[i*LenW +: LenW];
              wcnt  <= '0;
              req_q <= 1'b1;
              rdy_q <= 1'b0;
            end
          end
          S_WAIT: begin
            if (gnt) begin
              wcnt <= '0;
              if (rem == '0) begin
                st     <= S_DONE;
                req_q  <= 1'b0;
                done_q <= 1'b1;
              end else begin
                rem <= rem - LenW'(1);
                st  <= S_XFER;
              end
            end else if (wcnt == WaitLast) begin
              // Starvation is only reported; the request stays up.
              wcnt <= '0;
              to_q <= 1'b1;
            end else begin
              wcnt <= wcnt + CntW'(1);
            end
          end
          S_XFER: begin
            if (gnt) begin
              if (rem == '0) begin
                st     <= S_DONE;
                req_q  <= 1'b0;
                done_q <= 1'b1;
              end else begin
                rem <= rem - LenW'(1);
              end
            end else begin
              st   <= S_WAIT;
              wcnt <= '0;
            end
          end
          S_DONE: begin
            st    <= S_IDLE;
            rdy_q <= 1'b1;
          end
          default: begin
            st    <= S_IDLE;
            req_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arb_req_master.sv
// Randomised and directed bench for arb_req_master with a transaction-level
// reference model and an event scoreboard for done/timeout pulses.
module tb_arb_req_master;

  localparam int NR = 3;
  localparam int LW = 4;
  localparam int TO = 8;
  localparam int K_DONE = 0;
  localparam int K_TO   = 1;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic [NR-1:0]    start_in = '0;
  logic [NR-1:0]    start_ready_out;
  logic [NR*LW-1:0] len_in = '0;
  logic [NR-1:0]    req_out;
  logic [NR-1:0]    grant_in = '0;
  logic [NR-1:0]    beat_out;
  logic [NR-1:0]    done_out;
  logic [NR-1:0]    timeout_out;
  logic             err_out;
  logic             busy_out;

  arb_req_master #(.NumReq(NR), .LenW(LW), .TimeoutCycles(TO)) dut (
    .clk             (clk),
    .rstN            (rstN),
    .start_in        (start_in),
    .start_ready_out (start_ready_out),
    .len_in          (len_in),
    .req_out         (req_out),
    .grant_in        (grant_in),
    .beat_out        (beat_out),
    .done_out        (done_out),
    .timeout_out     (timeout_out),
    .err_out         (err_out),
    .busy_out        (busy_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Grant source: the only process writing grant_in, slightly after the falling edge.
  typedef enum int {G_ZERO, G_MAN, G_FOLLOW, G_RR, G_RAND} gmode_e;
  gmode_e        gmode = G_ZERO;
  logic [NR-1:0] man_grant = '0;
  logic [NR-1:0] fol_mask = '0;
  int            rr_last = NR - 1;

  always begin
    logic [NR-1:0] g;
    int base;
    int j;
    @(negedge clk);
    #1;
    g = '0;
    case (gmode)
      G_MAN:    g = man_grant;
      G_FOLLOW: g = req_out & fol_mask;
      G_RR: begin
        base = rr_last;
        for (int k = 1; k <= NR; k++) begin
          j = (base + k) % NR;
          if (g == '0 && req_out[j]) begin
            g[j] = 1'b1;
            rr_last = j;
          end
        end
      end
      G_RAND: begin
        if ($urandom_range(0, 3) != 0) begin
          base = $urandom_range(0, NR - 1);
          for (int k = 0; k < NR; k++) begin
            j = (base + k) % NR;
            if (g == '0 && req_out[j]) g[j] = 1'b1;
          end
        end
      end
      default: g = '0;
    endcase
    grant_in = g;
  end

  // Reference model: bursts as beat budgets, starvation as a run length of stalled cycles.
  typedef struct {int kind; int ch; int cyc; int beats;} exp_t;
  exp_t sb[$];
  int   cyc = 0;
  bit   act[NR];
  bit   pbeat[NR];
  int   left[NR];
  int   blen[NR];
  int   starve[NR];
  int   obs[NR];
  int   dn_at[NR];
  bit   err_m = 1'b0;

  function automatic void match(int kind, int ch, int seen);
    int idx = -1;
    foreach (sb[k]) if (idx < 0 && sb[k].kind == kind && sb[k].ch == ch) idx = k;
    if (idx < 0) begin
      check($sformatf("%s[%0d] unexpected at cycle %0d", kind == K_DONE ? "done_out" : "timeout_out", ch, cyc), seen, 0);
    end else begin
      check($sformatf("%s[%0d] cycle", kind == K_DONE ? "done_out" : "timeout_out", ch), cyc, sb[idx].cyc);
      if (kind == K_DONE) check($sformatf("beats ch%0d", ch), obs[ch], sb[idx].beats);
      sb.delete(idx);
    end
  endfunction

  initial begin
    logic [NR-1:0] rq;
    bit rdy;
    bit busy_e;
    for (int i = 0; i < NR; i++) begin
      act[i] = 0; pbeat[i] = 0; left[i] = 0; blen[i] = 0; starve[i] = 0; obs[i] = 0; dn_at[i] = -1;
    end
    forever begin
      @(negedge clk);
      #4;
      for (int i = 0; i < NR; i++) begin
        if (done_out[i]) match(K_DONE, i, done_out[i]);
        if (timeout_out[i]) match(K_TO, i, timeout_out[i]);
      end
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc <= cyc) begin
          if (sb[k].kind == K_DONE) check($sformatf("done_out[%0d] missing at cycle %0d", sb[k].ch, sb[k].cyc), done_out[sb[k].ch], 1);
          else check($sformatf("timeout_out[%0d] missing at cycle %0d", sb[k].ch, sb[k].cyc), timeout_out[sb[k].ch], 1);
          sb.delete(k);
        end
      end
      busy_e = 1'b0;
      rq = '0;
      for (int i = 0; i < NR; i++) begin
        rdy = !act[i] && dn_at[i] != cyc;
        busy_e |= !rdy;
        rq[i] = act[i];
        check($sformatf("req_out[%0d] cyc %0d", i, cyc), req_out[i], act[i]);
        check($sformatf("start_ready_out[%0d] cyc %0d", i, cyc), start_ready_out[i], rdy);
      end
      check($sformatf("beat_out cyc %0d", cyc), beat_out, req_out & grant_in);
      check($sformatf("err_out cyc %0d", cyc), err_out, err_m);
      check($sformatf("busy_out cyc %0d", cyc), busy_out, busy_e);
      for (int i = 0; i < NR; i++) obs[i] += int'(beat_out[i]);

      if (!rstN) begin
        for (int i = 0; i < NR; i++) begin
          act[i] = 0; pbeat[i] = 0; starve[i] = 0; dn_at[i] = -1;
        end
        sb.delete();
        err_m = 1'b0;
      end else begin
        if ($countones(grant_in) > 1 || (grant_in & ~rq) != '0) err_m = 1'b1;
        for (int i = 0; i < NR; i++) begin
          if (!act[i]) begin
            if (dn_at[i] != cyc && start_in[i]) begin
              act[i] = 1; blen[i] = int'(len_in[i*LW +: LW]) + 1; left[i] = blen[i];
              starve[i] = 0; pbeat[i] = 0; obs[i] = 0;
            end
          end else if (grant_in[i]) begin
            left[i]--; pbeat[i] = 1; starve[i] = 0;
            if (left[i] == 0) begin
              act[i] = 0;
              dn_at[i] = cyc + 1;
              sb.push_back('{K_DONE, i, cyc + 1, blen[i]});
            end
          end else if (pbeat[i]) begin
            pbeat[i] = 0;
          end else begin
            starve[i]++;
            if (starve[i] == TO) begin
              starve[i] = 0;
              sb.push_back('{K_TO, i, cyc + 1, 0});
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic issue(input logic [NR-1:0] m, input logic [NR*LW-1:0] l);
    start_in = m;
    len_in   = l;
    @(negedge clk);
    start_in = '0;
  endtask

  task automatic wait_req(input int ch);
    for (int k = 0; k < 50 && !req_out[ch]; k++) @(negedge clk);
    check($sformatf("req_out[%0d] rise", ch), req_out[ch], 1);
  endtask

  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim && busy_out; k++) @(negedge clk);
    check("drain busy_out", busy_out, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below %0d", cyc, 30000);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (10) @(negedge clk);

    // single burst, grant follows request
    gmode = G_FOLLOW; fol_mask = 3'b001;
    issue(3'b001, {4'd0, 4'd0, 4'd3});
    wait_idle(40);
    repeat (2) @(negedge clk);

    // grant loss mid-burst: 2 on, 3 off, 4 on
    gmode = G_MAN; man_grant = '0;
    issue(3'b010, {4'd0, 4'd5, 4'd0});
    wait_req(1);
    man_grant = 3'b010; repeat (2) @(negedge clk);
    man_grant = 3'b000; repeat (3) @(negedge clk);
    man_grant = 3'b010; repeat (4) @(negedge clk);
    man_grant = 3'b000;
    wait_idle(20);

    // starvation then completion
    gmode = G_ZERO;
    issue(3'b100, {4'd1, 4'd0, 4'd0});
    wait_req(2);
    repeat (20) @(negedge clk);
    gmode = G_FOLLOW; fol_mask = 3'b100;
    wait_idle(20);

    // all channels, single beat, round-robin arbiter in the loop
    gmode = G_RR; rr_last = NR - 1;
    issue(3'b111, '0);
    wait_idle(20);
    repeat (2) @(negedge clk);

    // protocol errors
    gmode = G_MAN; man_grant = '0;
    issue(3'b011, {4'd0, 4'd7, 4'd7});
    wait_req(0);
    man_grant = 3'b011; @(negedge clk);
    man_grant = 3'b000; repeat (5) @(negedge clk);
    rstN = 1'b0; @(negedge clk);
    rstN = 1'b1; repeat (2) @(negedge clk);
    man_grant = 3'b100; @(negedge clk);
    man_grant = 3'b000; repeat (3) @(negedge clk);
    rstN = 1'b0; @(negedge clk);
    rstN = 1'b1; repeat (2) @(negedge clk);

    // random traffic with occasional mid-burst resets
    gmode = G_RAND;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NR; i++) start_in[i] = ($urandom_range(0, 3) == 0);
      len_in = NR*LW'($urandom);
      rstN   = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    start_in = '0;
    rstN = 1'b1;
    gmode = G_RR;
    wait_idle(300);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
